// File: rtl/video_timing_monitor.sv
// video_timing_monitor: measures line/frame timing from HBLANK, VBLANK and CE_PIXEL with
// saturating counters and a frame-stability detector. Define VIDEO_TIMING_MON_SYNC_EN for sync-width measurement.
module video_timing_monitor #(
  parameter int WIDTH           = 16,
  parameter int STABLE_FRAMES   = 4,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       HBLANK,
  input  logic                       VBLANK,
  input  logic                       CE_PIXEL,
`ifdef VIDEO_TIMING_MON_SYNC_EN
  input  logic                       HSYNC,
  input  logic                       VSYNC,
  output logic [WIDTH-1:0]           hsync_clocks,
  output logic [WIDTH-1:0]           vsync_lines,
`endif
  output logic [WIDTH-1:0]           x_clocks,
  output logic [WIDTH-1:0]           x_unblanked,
  output logic [WIDTH-1:0]           x_ce_enable,
  output logic [WIDTH-1:0]           x_pixels,
  output logic [WIDTH-1:0]           y_lines,
  output logic [WIDTH-1:0]           y_unblanked,
  output logic                       x_valid,
  output logic                       y_valid,
  output logic                       overflow,
  output logic                       stable,
  output logic                       changed,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int SCW = $clog2(STABLE_FRAMES + 1);
`ifdef VIDEO_TIMING_MON_SYNC_EN
  localparam int SNAP_W = 8 * WIDTH;
`else
  localparam int SNAP_W = 6 * WIDTH;
`endif

  // Returns {increment attempted at all-ones, next value}; the value never wraps.
  function automatic logic [WIDTH:0] satInc(input logic [WIDTH-1:0] v, input logic inc);
    if (inc && (&v)) return {1'b1, v};
    return {1'b0, v + WIDTH'(inc)};
  endfunction

  logic              r_hb_prev, r_vb_prev;
  logic              r_hedge_seen, r_vedge_seen;
  logic [WIDTH-1:0]  r_x_clocks_c, r_x_unblanked_c, r_x_ce_c, r_x_pixels_c;
  logic [WIDTH-1:0]  r_y_lines_c, r_y_unblanked_c;
  logic [SCW-1:0]    r_stab_cnt;
  logic [SNAP_W-1:0] r_snap;

  logic              w_hedge, w_vedge, w_ovf, w_ovf_base;
  logic [SNAP_W-1:0] w_snap;
  logic [WIDTH:0]    w_x_clocks_n, w_x_unblanked_n, w_x_ce_n, w_x_pixels_n;
  logic [WIDTH:0]    w_y_lines_n, w_y_unblanked_n;

  assign w_hedge = HBLANK & ~r_hb_prev;
  assign w_vedge = VBLANK & ~r_vb_prev;

  assign w_x_clocks_n    = satInc(r_x_clocks_c, 1'b1);
  assign w_x_unblanked_n = satInc(r_x_unblanked_c, ~HBLANK);
  assign w_x_ce_n        = satInc(r_x_ce_c, CE_PIXEL);
  assign w_x_pixels_n    = satInc(r_x_pixels_c, ~HBLANK & CE_PIXEL);
  assign w_y_lines_n     = satInc(r_y_lines_c, w_hedge);
  assign w_y_unblanked_n = satInc(r_y_unblanked_c, w_hedge & ~VBLANK);

  // Reloads on an edge never count as saturation, only blocked increments do.
  assign w_ovf_base = (~w_hedge & (w_x_clocks_n[WIDTH] | w_x_unblanked_n[WIDTH] |
                                   w_x_ce_n[WIDTH] | w_x_pixels_n[WIDTH])) |
                      (~w_vedge & (w_y_lines_n[WIDTH] | w_y_unblanked_n[WIDTH]));

`ifdef VIDEO_TIMING_MON_SYNC_EN
  logic             r_hs_prev, r_vs_prev;
  logic [WIDTH-1:0] r_hs_c, r_vs_c;
  logic [WIDTH:0]   w_hs_n, w_vs_n;
  logic             w_hs_fall, w_vs_fall;

  assign w_hs_fall = ~HSYNC & r_hs_prev;
  assign w_vs_fall = ~VSYNC & r_vs_prev;
  assign w_hs_n    = satInc(r_hs_c, HSYNC);
  assign w_vs_n    = satInc(r_vs_c, w_hedge & VSYNC);
  assign w_ovf     = w_ovf_base | w_hs_n[WIDTH] | w_vs_n[WIDTH];
  assign w_snap    = {x_clocks, x_unblanked, x_ce_enable, x_pixels,
                      r_y_lines_c, r_y_unblanked_c, hsync_clocks, vsync_lines};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_prev    <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_hs_c       <= '0;
      r_vs_c       <= '0;
      hsync_clocks <= '0;
      vsync_lines  <= '0;
    end else begin
      r_hs_prev <= HSYNC;
      r_vs_prev <= VSYNC;
      if (w_hs_fall) begin
        hsync_clocks <= r_hs_c;
        r_hs_c       <= '0;
      end else begin
        r_hs_c <= w_hs_n[WIDTH-1:0];
      end
      if (w_vs_fall) begin
        vsync_lines <= r_vs_c;
        r_vs_c      <= '0;
      end else begin
        r_vs_c <= w_vs_n[WIDTH-1:0];
      end
    end
  end
`else
  assign w_ovf  = w_ovf_base;
  assign w_snap = {x_clocks, x_unblanked, x_ce_enable, x_pixels, r_y_lines_c, r_y_unblanked_c};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hb_prev       <= 1'b1;
      r_vb_prev       <= 1'b1;
      r_hedge_seen    <= 1'b0;
      r_vedge_seen    <= 1'b0;
      r_x_clocks_c    <= '0;
      r_x_unblanked_c <= '0;
      r_x_ce_c        <= '0;
      r_x_pixels_c    <= '0;
      r_y_lines_c     <= '0;
      r_y_unblanked_c <= '0;
      r_stab_cnt      <= '0;
      r_snap          <= '0;
      x_clocks        <= '0;
      x_unblanked     <= '0;
      x_ce_enable     <= '0;
      x_pixels        <= '0;
      y_lines         <= '0;
      y_unblanked     <= '0;
      x_valid         <= 1'b0;
      y_valid         <= 1'b0;
      overflow        <= 1'b0;
      stable          <= 1'b0;
      changed         <= 1'b0;
      frame_count     <= '0;
    end else begin
      r_hb_prev <= HBLANK;
      r_vb_prev <= VBLANK;
      changed   <= 1'b0;
      if (w_ovf) overflow <= 1'b1;

      if (w_hedge) begin
        x_clocks        <= r_x_clocks_c;
        x_unblanked     <= r_x_unblanked_c;
        x_ce_enable     <= r_x_ce_c;
        x_pixels        <= r_x_pixels_c;
        r_x_clocks_c    <= WIDTH'(1);
        r_x_unblanked_c <= '0;
        r_x_ce_c        <= WIDTH'(CE_PIXEL);
        r_x_pixels_c    <= '0;
        r_hedge_seen    <= 1'b1;
        if (r_hedge_seen) x_valid <= 1'b1;
      end else begin
        r_x_clocks_c    <= w_x_clocks_n[WIDTH-1:0];
        r_x_unblanked_c <= w_x_unblanked_n[WIDTH-1:0];
        r_x_ce_c        <= w_x_ce_n[WIDTH-1:0];
        r_x_pixels_c    <= w_x_pixels_n[WIDTH-1:0];
      end

      // A frame edge swallows a line edge landing in the same cycle.
      if (w_vedge) begin
        y_lines         <= r_y_lines_c;
        y_unblanked     <= r_y_unblanked_c;
        r_y_lines_c     <= '0;
        r_y_unblanked_c <= '0;
        frame_count     <= frame_count + FRAME_CNT_WIDTH'(1);
        r_vedge_seen    <= 1'b1;
        if (r_vedge_seen) y_valid <= 1'b1;
        r_snap          <= w_snap;
        if (y_valid) begin
          if (w_snap == r_snap) begin
            if (r_stab_cnt != SCW'(STABLE_FRAMES)) r_stab_cnt <= r_stab_cnt + SCW'(1);
            stable <= (r_stab_cnt >= SCW'(STABLE_FRAMES - 1));
          end else begin
            r_stab_cnt <= '0;
            stable     <= 1'b0;
            changed    <= 1'b1;
          end
        end
      end else if (w_hedge) begin
        r_y_lines_c     <= w_y_lines_n[WIDTH-1:0];
        r_y_unblanked_c <= w_y_unblanked_n[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor: directed and randomized video timing checked every cycle against
// a window-based reference model (per-line sample queue, per-frame line queue, snapshot history).
module tb_video_timing_monitor;

  localparam int W    = 4;
  localparam int SF   = 4;
  localparam int FCW  = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset, HBLANK, VBLANK, CE_PIXEL;
  logic [W-1:0] x_clocks, x_unblanked, x_ce_enable, x_pixels, y_lines, y_unblanked;
  logic x_valid, y_valid, overflow, stable, changed;
  logic [FCW-1:0] frame_count;
`ifdef VIDEO_TIMING_MON_SYNC_EN
  logic [W-1:0] hsync_clocks, vsync_lines;
`endif

  int checkCount = 0;
  int errorCount = 0;

  video_timing_monitor #(.WIDTH(W), .STABLE_FRAMES(SF), .FRAME_CNT_WIDTH(FCW)) dut (
    .clk(clk),
    .reset(reset),
    .HBLANK(HBLANK),
    .VBLANK(VBLANK),
    .CE_PIXEL(CE_PIXEL),
`ifdef VIDEO_TIMING_MON_SYNC_EN
    .HSYNC(1'b0),
    .VSYNC(1'b0),
    .hsync_clocks(hsync_clocks),
    .vsync_lines(vsync_lines),
`endif
    .x_clocks(x_clocks),
    .x_unblanked(x_unblanked),
    .x_ce_enable(x_ce_enable),
    .x_pixels(x_pixels),
    .y_lines(y_lines),
    .y_unblanked(y_unblanked),
    .x_valid(x_valid),
    .y_valid(y_valid),
    .overflow(overflow),
    .stable(stable),
    .changed(changed),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: samples since the last line edge, line-edge VBLANK levels since the last frame edge.
  logic       mPrevHb, mPrevVb;
  logic [1:0] lineQ[$];
  logic       frameQ[$];
  int         expX[4];
  int         expY[2];
  int         prevSnap[6];
  int         hedgeCnt, vedgeCnt, runLen, expFrame;
  logic       expXValid, expYValid, expOvf, expStable, expChanged;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int lineStat(input int which);
    int n = 0;
    foreach (lineQ[i]) begin
      case (which)
        0:       n++;
        1:       if (!lineQ[i][1]) n++;
        2:       if (lineQ[i][0]) n++;
        default: if (!lineQ[i][1] && lineQ[i][0]) n++;
      endcase
    end
    return n;
  endfunction

  function automatic int frameUnblanked();
    int n = 0;
    foreach (frameQ[i]) if (!frameQ[i]) n++;
    return n;
  endfunction

  task automatic modelReset();
    mPrevHb = 1'b1;
    mPrevVb = 1'b1;
    lineQ.delete();
    frameQ.delete();
    for (int k = 0; k < 4; k++) expX[k] = 0;
    for (int k = 0; k < 2; k++) expY[k] = 0;
    for (int k = 0; k < 6; k++) prevSnap[k] = 0;
    hedgeCnt = 0; vedgeCnt = 0; runLen = 0; expFrame = 0;
    expXValid = 1'b0; expYValid = 1'b0; expOvf = 1'b0; expStable = 1'b0; expChanged = 1'b0;
  endtask

  task automatic modelStep(input logic rst, input logic hb, input logic vb, input logic ce);
    logic hedge, vedge, same;
    int   snap[6];
    if (rst) begin
      modelReset();
      return;
    end
    hedge   = hb && !mPrevHb;
    vedge   = vb && !mPrevVb;
    mPrevHb = hb;
    mPrevVb = vb;
    expChanged = 1'b0;
    if (vedge) begin
      for (int k = 0; k < 4; k++) snap[k] = expX[k];
      snap[4] = sat(frameQ.size());
      snap[5] = sat(frameUnblanked());
      if (expYValid) begin
        same = 1'b1;
        for (int k = 0; k < 6; k++) if (snap[k] != prevSnap[k]) same = 1'b0;
        if (same) runLen++;
        else begin
          runLen = 0;
          expChanged = 1'b1;
        end
        expStable = (runLen >= SF);
      end
      prevSnap = snap;
      expY[0]  = snap[4];
      expY[1]  = snap[5];
      frameQ.delete();
      vedgeCnt++;
      if (vedgeCnt >= 2) expYValid = 1'b1;
      expFrame = (expFrame + 1) % (1 << FCW);
    end else if (hedge) begin
      frameQ.push_back(vb);
    end
    if (hedge) begin
      for (int k = 0; k < 4; k++) expX[k] = sat(lineStat(k));
      lineQ.delete();
      lineQ.push_back({hb, ce});
      hedgeCnt++;
      if (hedgeCnt >= 2) expXValid = 1'b1;
    end else begin
      lineQ.push_back({hb, ce});
    end
    for (int k = 0; k < 4; k++) if (lineStat(k) > MAXV) expOvf = 1'b1;
    if (frameQ.size() > MAXV) expOvf = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("x_clocks", int'(x_clocks), expX[0]);
    checkOutput("x_unblanked", int'(x_unblanked), expX[1]);
    checkOutput("x_ce_enable", int'(x_ce_enable), expX[2]);
    checkOutput("x_pixels", int'(x_pixels), expX[3]);
    checkOutput("y_lines", int'(y_lines), expY[0]);
    checkOutput("y_unblanked", int'(y_unblanked), expY[1]);
    checkOutput("x_valid", int'(x_valid), int'(expXValid));
    checkOutput("y_valid", int'(y_valid), int'(expYValid));
    checkOutput("overflow", int'(overflow), int'(expOvf));
    checkOutput("stable", int'(stable), int'(expStable));
    checkOutput("changed", int'(changed), int'(expChanged));
    checkOutput("frame_count", int'(frame_count), expFrame);
  endtask

  task automatic applyStimulus(input logic rst, input logic hb, input logic vb, input logic ce);
    reset    = rst;
    HBLANK   = hb;
    VBLANK   = vb;
    CE_PIXEL = ce;
    @(posedge clk);
    modelStep(rst, hb, vb, ce);
    @(negedge clk);
    checkAll();
  endtask

  task automatic runFrames(input int nFrames, input int lineLen, input int hbStart, input int nLines,
                           input int vbLine, input int vbCycle, input logic randCe);
    for (int f = 0; f < nFrames; f++)
      for (int l = 0; l < nLines; l++)
        for (int c = 0; c < lineLen; c++) begin
          logic hb, vb, ce;
          hb = (c >= hbStart);
          vb = (l > vbLine) || (l == vbLine && c >= vbCycle);
          if (randCe) ce = 1'($urandom_range(0, 1));
          else        ce = (c % 2 == 0);
          applyStimulus(1'b0, hb, vb, ce);
        end
  endtask

  initial begin
    modelReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_x_clocks", int'(x_clocks), 0);
    checkOutput("rst_frame_count", int'(frame_count), 0);

    // Baseline 10-clock lines, 6-line frames
    runFrames(2, 10, 8, 6, 4, 0, 1'b0);
    checkOutput("dir_x_clocks", int'(x_clocks), 10);
    checkOutput("dir_x_unblanked", int'(x_unblanked), 8);
    checkOutput("dir_x_ce_enable", int'(x_ce_enable), 5);
    checkOutput("dir_x_pixels", int'(x_pixels), 4);
    checkOutput("dir_y_lines", int'(y_lines), 6);
    checkOutput("dir_y_unblanked", int'(y_unblanked), 4);
    checkOutput("dir_x_valid", int'(x_valid), 1);
    checkOutput("dir_y_valid", int'(y_valid), 1);
    runFrames(3, 10, 8, 6, 4, 0, 1'b0);
    checkOutput("dir_stable_5frames", int'(stable), 0);
    runFrames(1, 10, 8, 6, 4, 0, 1'b0);
    checkOutput("dir_stable_6frames", int'(stable), 1);

    // Line length change to 12
    runFrames(1, 12, 10, 6, 4, 0, 1'b0);
    checkOutput("dir_stable_after_change", int'(stable), 0);
    checkOutput("dir_x_clocks_12", int'(x_clocks), 12);
    runFrames(3, 12, 10, 6, 4, 0, 1'b0);
    checkOutput("dir_stable_3_after", int'(stable), 0);
    runFrames(1, 12, 10, 6, 4, 0, 1'b0);
    checkOutput("dir_stable_reassert", int'(stable), 1);

    // Frame edge coinciding with a line edge
    runFrames(3, 10, 8, 6, 4, 8, 1'b0);
    checkOutput("dir_same_y_lines", int'(y_lines), 5);
    checkOutput("dir_same_y_unblanked", int'(y_unblanked), 4);
    checkOutput("dir_same_x_clocks", int'(x_clocks), 10);

    // Reset mid-frame
    for (int c = 0; c < 15; c++) applyStimulus(1'b0, 1'((c % 10) >= 8), 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_x_clocks", int'(x_clocks), 0);
    checkOutput("midrst_y_lines", int'(y_lines), 0);
    checkOutput("midrst_frame_count", int'(frame_count), 0);
    checkOutput("midrst_y_valid", int'(y_valid), 0);

    // Blanking held high through reset release
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_frame_count", int'(frame_count), 0);
    checkOutput("hold_x_clocks", int'(x_clocks), 0);
    checkOutput("hold_x_valid", int'(x_valid), 0);
    runFrames(1, 10, 8, 6, 4, 0, 1'b0);
    checkOutput("hold_first_vedge_count", int'(frame_count), 1);
    checkOutput("hold_first_vedge_yvalid", int'(y_valid), 0);

    // Randomized timings, each held for a few frames
    for (int t = 0; t < 12; t++) begin
      int len, hbs, nl, vbl, vbc, nf;
      len = $urandom_range(5, 18);
      hbs = $urandom_range(1, len - 1);
      nl  = $urandom_range(3, 9);
      vbl = $urandom_range(1, nl - 1);
      vbc = $urandom_range(0, len - 1);
      nf  = $urandom_range(1, 6);
      runFrames(nf, len, hbs, nl, vbl, vbc, 1'($urandom_range(0, 1)));
    end

    // Saturation: 40 unblanked clocks with a 4-bit counter
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_x_clocks", int'(x_clocks), 15);
    checkOutput("sat_overflow", int'(overflow), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_overflow_sticky", int'(overflow), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
